// File: rtl/wfull_ctrl.sv
// rtl/wfull_ctrl.sv - write-domain pointer, full, almost-full, level and overflow control
// Synchronises the read Gray pointer into wclk and derives all write-side status from it.
module wfull_ctrl #(
  parameter int ASIZE       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             wen,
  input  logic [ASIZE:0]   rptr_gray,
  input  logic [ASIZE:0]   afull_thresh,
  input  logic             ovf_clr,
  output logic [ASIZE:0]   wptr,
  output logic [ASIZE-1:0] waddr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             wovf
);

  logic [ASIZE:0] r_sync [SYNC_STAGES];
  logic [ASIZE:0] r_bin;
  logic [ASIZE:0] r_gray;
  logic [ASIZE:0] r_level;
  logic           r_full;
  logic           r_afull;
  logic           r_ovf;

  logic [ASIZE:0] w_rq;
  logic [ASIZE:0] w_rbin;
  logic [ASIZE:0] w_bin_next;
  logic [ASIZE:0] w_gray_next;
  logic [ASIZE:0] w_lvl_next;
  logic           w_wacc;
  logic           w_full_next;

  // Plain flop chain: nothing combinational may sit between stages.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= rptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_rq = r_sync[SYNC_STAGES-1];

  // Binary bit i is the XOR of Gray bits i..ASIZE.
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= ASIZE; i++) w_rbin[i] = ^(w_rq >> i);
  end

  assign w_wacc      = wen & ~r_full;
  assign w_bin_next  = r_bin + {{ASIZE{1'b0}}, w_wacc};
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);
  assign w_lvl_next  = w_bin_next - w_rbin;
  assign w_full_next = (w_gray_next[ASIZE:ASIZE-1] == ~w_rq[ASIZE:ASIZE-1]) &&
                       (w_gray_next[ASIZE-2:0] == w_rq[ASIZE-2:0]);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_bin   <= w_bin_next;
      r_gray  <= w_gray_next;
      r_level <= w_lvl_next;
      r_full  <= w_full_next;
      r_afull <= (w_lvl_next >= afull_thresh);
      // A set on the same edge as a clear wins.
      r_ovf   <= (wen & r_full) | (r_ovf & ~ovf_clr);
    end
  end

  assign wptr         = r_gray;
  assign waddr        = r_bin[ASIZE-1:0];
  assign wfull        = r_full;
  assign walmost_full = r_afull;
  assign wlevel       = r_level;
  assign wovf         = r_ovf;

endmodule

// File: tb/tb_wfull_ctrl.sv
// tb/tb_wfull_ctrl.sv - directed self-checking bench for wfull_ctrl
// Linear stimulus with hand-computed expectations for ASIZE=4, SYNC_STAGES=2.
module tb_wfull_ctrl;

  logic       wclk;
  logic       wrst_n;
  logic       wen;
  logic [4:0] rptr_gray;
  logic [4:0] afull_thresh;
  logic       ovf_clr;
  logic [4:0] wptr;
  logic [3:0] waddr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       wovf;

  int n_chk  = 0;
  int n_pass = 0;
  int mb;
  logic [4:0] prev;

  wfull_ctrl #(.ASIZE(4), .SYNC_STAGES(2)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .wen          (wen),
    .rptr_gray    (rptr_gray),
    .afull_thresh (afull_thresh),
    .ovf_clr      (ovf_clr),
    .wptr         (wptr),
    .waddr        (waddr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .wovf         (wovf)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [4:0] g(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    wrst_n = 1'b0; wen = 1'b0; rptr_gray = '0; afull_thresh = 5'd12; ovf_clr = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    check("rst_wptr", 32'(wptr), 0);
    check("rst_waddr", 32'(waddr), 0);
    check("rst_wlevel", 32'(wlevel), 0);
    check("rst_wfull", 32'(wfull), 0);
    check("rst_afull", 32'(walmost_full), 0);
    check("rst_wovf", 32'(wovf), 0);
    wrst_n = 1'b1;

    // Fill 16 back-to-back writes
    for (int k = 1; k <= 16; k++) begin
      check("fill_waddr", 32'(waddr), 32'(k - 1));
      wen = 1'b1;
      step();
      check("fill_wptr", 32'(wptr), 32'(g(k)));
      check("fill_wlevel", 32'(wlevel), 32'(k));
      check("fill_wfull", 32'(wfull), (k == 16) ? 1 : 0);
      check("fill_afull", 32'(walmost_full), (k >= 12) ? 1 : 0);
    end
    check("full_wptr", 32'(wptr), 32'h18);

    // Overflow while full
    for (int k = 0; k < 3; k++) begin
      step();
      check("ovf_wptr", 32'(wptr), 32'h18);
      check("ovf_wlevel", 32'(wlevel), 16);
      check("ovf_set", 32'(wovf), 1);
    end
    ovf_clr = 1'b1;
    step();
    check("ovf_set_wins", 32'(wovf), 1);
    wen = 1'b0;
    step();
    check("ovf_clr", 32'(wovf), 0);
    ovf_clr = 1'b0;

    // Release: read pointer to 4, visible two edges later
    rptr_gray = g(4);
    step();
    check("rel_e0_wfull", 32'(wfull), 1);
    step();
    check("rel_e1_wfull", 32'(wfull), 1);
    check("rel_e1_wlevel", 32'(wlevel), 16);
    step();
    check("rel_e2_wfull", 32'(wfull), 0);
    check("rel_e2_wlevel", 32'(wlevel), 12);
    check("rel_e2_afull", 32'(walmost_full), 1);

    // Wrap with synchronised read pointer 3 behind
    mb = 16;
    rptr_gray = g(14);
    repeat (3) step();
    check("pre_wlevel", 32'(wlevel), 2);
    rptr_gray = g(15);
    step();
    prev = wptr;
    for (int i = 0; i < 40; i++) begin
      rptr_gray = g(mb);
      wen = 1'b1;
      step();
      mb = (mb + 1) % 32;
      check("wrap_wptr", 32'(wptr), 32'(g(mb)));
      check("wrap_wlevel", 32'(wlevel), 3);
      check("wrap_wfull", 32'(wfull), 0);
      check("wrap_afull", 32'(walmost_full), 0);
      check("wrap_gray1", $countones(wptr ^ prev), 1);
      if (mb == 0) check("wrap_waddr0", 32'(waddr), 0);
      prev = wptr;
    end
    wen = 1'b0;

    // Threshold 0: asserts from first edge after reset
    afull_thresh = 5'd0;
    rptr_gray = '0;
    wrst_n = 1'b0;
    #1;
    check("t0_rst_afull", 32'(walmost_full), 0);
    check("t0_rst_wlevel", 32'(wlevel), 0);
    step();
    wrst_n = 1'b1;
    step();
    check("t0_afull", 32'(walmost_full), 1);
    check("t0_wlevel", 32'(wlevel), 0);

    // Threshold 17 plus asynchronous reset mid-run
    afull_thresh = 5'd17;
    wrst_n = 1'b0;
    #1;
    wrst_n = 1'b1;
    wen = 1'b1;
    repeat (8) step();
    check("mid_wptr", 32'(wptr), 32'h0C);
    wen = 1'b0;
    #3;
    wrst_n = 1'b0;
    #1;
    check("async_wptr", 32'(wptr), 0);
    check("async_waddr", 32'(waddr), 0);
    check("async_wlevel", 32'(wlevel), 0);
    check("async_wfull", 32'(wfull), 0);
    check("async_afull", 32'(walmost_full), 0);
    step();
    wrst_n = 1'b1;
    step();
    check("rel_wptr", 32'(wptr), 0);
    check("rel_wlevel", 32'(wlevel), 0);
    wen = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check("t17_afull", 32'(walmost_full), 0);
    end
    check("t17_wfull", 32'(wfull), 1);
    check("t17_wlevel", 32'(wlevel), 16);
    step();
    check("t17_wovf", 32'(wovf), 1);
    check("t17_afull_full", 32'(walmost_full), 0);
    wen = 1'b0;
    #2;
    wrst_n = 1'b0;
    #1;
    check("async_wovf", 32'(wovf), 0);
    check("async_wfull2", 32'(wfull), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wfull_ctrl.md
# wfull_ctrl

Write-domain controller for the dual-clock FIFO with parameterised depth and synchroniser length. It synchronises the read-side Gray pointer into `wclk` and generates the Gray/binary write pointers. It also provides a registered full flag, a programmable almost-full watermark, a write-side fill level and a sticky overflow flag. It sits between the write client and the FIFO RAM write port, and its `wptr` feeds the read-domain synchroniser.

## Interface
- `ASIZE`, default 4: address width; FIFO depth is 2^ASIZE; legal values ≥ 2.
- `SYNC_STAGES`, default 2: flop stages on the read-pointer synchroniser; legal values ≥ 2.
- `wclk` input 1: write clock.
- `wrst_n` input 1: reset, asynchronous, active-low; clock wclk.
- `wen` input 1: write request from the client.
- `rptr_gray` input ASIZE+1: read pointer in Gray code, from the read domain, unsynchronised.
- `afull_thresh` input ASIZE+1: almost-full watermark, quasi-static.
- `ovf_clr` input 1: clears `wovf`.
- `wptr` output ASIZE+1: registered write pointer in Gray code, sent to the read domain.
- `waddr` output ASIZE: RAM write address, equal to binary pointer bits [ASIZE-1:0].
- `wfull` output 1: registered full flag.
- `walmost_full` output 1: registered, asserted when the fill level is ≥ `afull_thresh`.
- `wlevel` output ASIZE+1: registered fill level, range 0..2^ASIZE; a conservative (over-)estimate.
- `wovf` output 1: sticky flag; set by a write attempt while full.

## Operation
- **Synchroniser:** a chain of SYNC_STAGES flops on `rptr_gray`, all reset to 0; `rq` is the last stage. No logic sits between the stages.
- **Gray-to-binary:** `rbin[ASIZE] = rq[ASIZE]`; `rbin[i] = rbin[i+1] ^ rq[i]`.
- **Accept:** `wacc = wen & ~wfull`.
- **Pointer update:** `bin_next = bin + wacc` (mod 2^(ASIZE+1)); `gray_next = bin_next ^ (bin_next >> 1)`. `bin` and `gray` register these values each edge.
- **Outputs:** `wptr = gray`, `waddr = bin[ASIZE-1:0]`. The RAM writes `waddr` on the same edge where `wacc` = 1.
- **Level:** `lvl_next = (bin_next - rbin) mod 2^(ASIZE+1)`; `wlevel` registers `lvl_next`.
- **Full:** `wfull` registers the condition (`gray_next[ASIZE:ASIZE-1] == ~rq[ASIZE:ASIZE-1]`) and (`gray_next[ASIZE-2:0] == rq[ASIZE-2:0]`). This condition is equivalent to `lvl_next == 2^ASIZE`.
  - Invariant: `wfull == (wlevel == 2^ASIZE)` on every cycle.
- **Almost full:** `walmost_full` registers `lvl_next >= afull_thresh`, as an unsigned compare.
  - `afull_thresh` = 0 gives 1 from the first edge after reset onward.
  - `afull_thresh` > 2^ASIZE gives a flag that never asserts.
- **Overflow:** `wovf` is set on an edge with `wen & wfull`. It is cleared on an edge with `ovf_clr`. If both occur on the same edge, set wins. A rejected write changes no other state.
- **Wrap-around:** the pointer wraps from 2^(ASIZE+1)-1 to 0. The level and full logic are correct across the wrap because all subtraction is modulo 2^(ASIZE+1).
- **Read-pointer staleness:** a stale `rq` can only over-report the level, so `wfull` may be pessimistic but never under-reports fullness.

## Timing
- **Reset values:** `wptr`, `waddr`, `wlevel` = 0; `wfull`, `walmost_full`, `wovf` = 0; all synchroniser stages = 0.
- **Reset mid-operation:** asynchronous assertion clears all of the above immediately, with no clock needed. Deassertion is synchronous to `wclk`, handled externally.
- **Accepted write:** `wptr`, `waddr`, `wlevel`, `wfull` and `walmost_full` all reflect it after the same edge, with zero extra latency. The 2^ASIZE-th outstanding write sets `wfull` on its own edge, so the next-cycle `wen` is rejected.
- **Read-pointer change:** if `rptr_gray` is stable before edge E0, `rq` holds the new value after edge E0+SYNC_STAGES-1. `wlevel`, `wfull` and `walmost_full` reflect it after edge E0+SYNC_STAGES.
- **Simultaneous write and read-pointer advance while full:** `wen` in the cycle where `wfull` is still 1 is rejected and sets `wovf`. `wfull` drops on the edge where the new `rq` is first used.
- **`ovf_clr`:** takes effect on the next edge; `wovf` = 0 after it unless overridden by a simultaneous set.

## Test plan
- **Reset:** assert `wrst_n`=0 mid-run with `wptr`=5'h0C → all outputs are 0 immediately; after release, `wptr`=0, `wlevel`=0.
- **Fill:** ASIZE=4, `rptr_gray`=0, `afull_thresh`=12, 16 back-to-back writes.
  - `walmost_full`=1 after the 12th edge.
  - `wfull`=1 and `wlevel`=16 after the 16th edge.
  - `wptr`=5'b11000 (bin 16).
  - `waddr` sequence 0..15.
- **Overflow:** while full, hold `wen` 3 cycles → `wptr` is unchanged and `wovf`=1.
  - Pulse `ovf_clr` together with `wen` → `wovf` stays 1.
  - Pulse `ovf_clr` alone → `wovf`=0.
- **Release:** from full, drive `rptr_gray`=gray(4) before edge E0, SYNC_STAGES=2 → `wfull`=0 and `wlevel`=12 after edge E0+2, not earlier.
- **Wrap:** cycle 40 writes with the read pointer tracking 3 behind (synchronised).
  - `bin` wraps 31→0.
  - `wlevel` stays 3, and `wfull` stays 0, throughout.
  - `wptr` is checked as a single-bit-change Gray sequence.
- **Threshold corners:** `afull_thresh`=0 → `walmost_full`=1 from the first edge after reset. `afull_thresh`=17 → `walmost_full` never asserts, including when full.
